// File: rtl/uart_tx.sv
// uart_tx: serialises one byte per request into an asynchronous frame
// (start, 8 data bits LSB first, optional parity, 1 or 2 stop bits).
module uart_tx #(
  parameter int unsigned CLK_FREQ     = 125_000_000,
  parameter int unsigned BAUD_RATE    = 115_200,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       iClk,
  input  logic       iRstN,
  input  logic       iTxStart,
  input  logic [7:0] iTxByte,
  output logic       oTxSerial,
  output logic       oTxBusy,
  output logic       oTxDone
);

  localparam int unsigned CNT_W = $clog2(2 * CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    sIdle   = 3'd0,
    sStart  = 3'd1,
    sData   = 3'd2,
    sParity = 3'd3,
    sStop   = 3'd4,
    sDone   = 3'd5
  } txState_t;

  txState_t         state;
  logic [CNT_W-1:0] cycCnt;
  logic [2:0]       bitCnt;
  logic [7:0]       shiftReg;
  logic             parityBit;
  logic             parityCalc;

  // Parity of the byte being accepted; odd parity is the inverse of the XOR.
  assign parityCalc = (PARITY == 2) ? ~(^iTxByte) : (^iTxByte);

  // Frame sequencer: every output is registered, so the line changes one
  // clock after the state decision that selects its next value.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state     <= sIdle;
      cycCnt    <= '0;
      bitCnt    <= '0;
      shiftReg  <= 8'h00;
      parityBit <= 1'b0;
      oTxSerial <= 1'b1;
      oTxBusy   <= 1'b0;
      oTxDone   <= 1'b0;
    end else begin
      case (state)
        sIdle: begin
          oTxSerial <= 1'b1;
          oTxBusy   <= 1'b0;
          oTxDone   <= 1'b0;
          cycCnt    <= '0;
          bitCnt    <= '0;
          if (iTxStart) begin
            shiftReg  <= iTxByte;
            parityBit <= parityCalc;
            state     <= sStart;
            oTxSerial <= 1'b0;
            oTxBusy   <= 1'b1;
          end
        end

        sStart: begin
          if (cycCnt == BIT_LAST) begin
            cycCnt    <= '0;
            bitCnt    <= '0;
            state     <= sData;
            oTxSerial <= shiftReg[0];
          end else begin
            cycCnt <= cycCnt + CNT_W'(1);
          end
        end

        sData: begin
          if (cycCnt == BIT_LAST) begin
            cycCnt <= '0;
            if (bitCnt == 3'd7) begin
              if (PARITY != 0) begin
                state     <= sParity;
                oTxSerial <= parityBit;
              end else begin
                state     <= sStop;
                oTxSerial <= 1'b1;
              end
            end else begin
              bitCnt    <= bitCnt + 3'd1;
              shiftReg  <= {1'b0, shiftReg[7:1]};
              oTxSerial <= shiftReg[1];
            end
          end else begin
            cycCnt <= cycCnt + CNT_W'(1);
          end
        end

        sParity: begin
          if (cycCnt == BIT_LAST) begin
            cycCnt    <= '0;
            state     <= sStop;
            oTxSerial <= 1'b1;
          end else begin
            cycCnt <= cycCnt + CNT_W'(1);
          end
        end

        sStop: begin
          if (cycCnt == STOP_LAST) begin
            cycCnt    <= '0;
            state     <= sDone;
            oTxDone   <= 1'b1;
            oTxSerial <= 1'b1;
          end else begin
            cycCnt <= cycCnt + CNT_W'(1);
          end
        end

        sDone: begin
          state     <= sIdle;
          oTxDone   <= 1'b0;
          oTxBusy   <= 1'b0;
          oTxSerial <= 1'b1;
        end

        default: begin
          state     <= sIdle;
          cycCnt    <= '0;
          bitCnt    <= '0;
          oTxSerial <= 1'b1;
          oTxBusy   <= 1'b0;
          oTxDone   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances cover no/even/odd parity and two stop
// bits; a queue of expected line bits per frame is the reference.
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int NU  = 4;

  logic       clk;
  logic       rstN;
  logic       txStart [NU];
  logic [7:0] txByte  [NU];
  wire        txSerial[NU];
  wire        txBusy  [NU];
  wire        txDone  [NU];

  int nCmp = 0;
  int nErr = 0;

  // Instance g: parity 0/1/2/0, stop bits 1/1/1/2.
  for (genvar g = 0; g < NU; g++) begin : gU
    uart_tx #(
      .CLKS_PER_BIT(CPB),
      .PARITY      ((g == 1) ? 1 : ((g == 2) ? 2 : 0)),
      .STOP_BITS   ((g == 3) ? 2 : 1)
    ) dut (
      .iClk     (clk),
      .iRstN    (rstN),
      .iTxStart (txStart[g]),
      .iTxByte  (txByte[g]),
      .oTxSerial(txSerial[g]),
      .oTxBusy  (txBusy[g]),
      .oTxDone  (txDone[g])
    );
  end

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int k, input logic obs, input logic exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  task automatic chkIdle(input int idx, input string tag);
    chk($sformatf("u%0d %s serial", idx, tag), 0, txSerial[idx], 1'b1);
    chk($sformatf("u%0d %s busy", idx, tag), 0, txBusy[idx], 1'b0);
    chk($sformatf("u%0d %s done", idx, tag), 0, txDone[idx], 1'b0);
  endtask

  // Start a frame on unit idx (caller sits just after a falling edge) and
  // check the line, busy and done on every cycle through the trailing IDLE.
  task automatic sendFrame(input int idx, input logic [7:0] b, input bit hold, input bit noise);
    bit q[$];
    int par, stops, len;
    par   = (idx == 1) ? 1 : ((idx == 2) ? 2 : 0);
    stops = (idx == 3) ? 2 : 1;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(b[i]);
    if (par != 0) q.push_back((^b) ^ (par == 2));
    for (int i = 0; i < stops; i++) q.push_back(1'b1);
    len = q.size() * CPB;
    txStart[idx] = 1'b1;
    txByte[idx]  = b;
    for (int k = 0; k <= len + 1; k++) begin
      @(negedge clk);
      if (k < len) begin
        chk($sformatf("u%0d byte %h serial", idx, b), k, txSerial[idx], q[k / CPB]);
        chk($sformatf("u%0d byte %h busy", idx, b), k, txBusy[idx], 1'b1);
        chk($sformatf("u%0d byte %h done", idx, b), k, txDone[idx], 1'b0);
      end else if (k == len) begin
        chk($sformatf("u%0d byte %h done-serial", idx, b), k, txSerial[idx], 1'b1);
        chk($sformatf("u%0d byte %h done-busy", idx, b), k, txBusy[idx], 1'b1);
        chk($sformatf("u%0d byte %h done-pulse", idx, b), k, txDone[idx], 1'b1);
      end else begin
        chkIdle(idx, "gap");
      end
      if (!hold) begin
        if (noise && k <= len) begin
          txStart[idx] = 1'($urandom);
          txByte[idx]  = 8'h00;
        end else begin
          txStart[idx] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    clk  = 1'b0;
    rstN = 1'b0;
    for (int i = 0; i < NU; i++) begin
      txStart[i] = 1'b0;
      txByte[i]  = 8'h00;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < NU; i++) chkIdle(i, "in-reset");
    rstN = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NU; i++) chkIdle(i, "after-reset");

    // Directed frames per configuration.
    sendFrame(0, 8'h55, 1'b0, 1'b0);
    sendFrame(1, 8'hA3, 1'b0, 1'b0);
    sendFrame(2, 8'hA3, 1'b0, 1'b0);
    sendFrame(3, 8'hFF, 1'b0, 1'b0);

    // Random bytes on every configuration.
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < NU; i++)
        sendFrame(i, 8'($urandom), 1'b0, 1'b0);

    // Requests and byte changes during a frame must not disturb it.
    sendFrame(0, 8'h0F, 1'b0, 1'b1);
    sendFrame(2, 8'($urandom), 1'b0, 1'b1);

    // Start held high: back-to-back frames with a 2-cycle high gap.
    sendFrame(0, 8'h81, 1'b1, 1'b0);
    sendFrame(0, 8'h81, 1'b1, 1'b0);
    sendFrame(0, 8'h81, 1'b0, 1'b0);
    @(negedge clk);
    chkIdle(0, "post-hold");

    // Asynchronous reset in the middle of data bit 3.
    txStart[0] = 1'b1;
    txByte[0]  = 8'h96;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      txStart[0] = 1'b0;
    end
    chk("pre-reset serial", 17, txSerial[0], 1'b0);
    chk("pre-reset busy", 17, txBusy[0], 1'b1);
    #2 rstN = 1'b0;
    #1;
    chkIdle(0, "async-reset");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chkIdle(0, "held-reset");
    end
    rstN = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chkIdle(0, "post-reset");
    end
    sendFrame(0, 8'h3C, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
